pipeline_hazard_ctrl: RTL and testbench

- Central hazard scheduler for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB) executing LD, SD, BEQ-class branches, R-type and I-type ALU ops.
- Decodes source registers of the instruction in ID and compares them against the EX-stage load.
- Combines load-use, taken-branch and data-memory-wait conditions into per-register write enables, bubble insertion and flushes.
- Tracks memory wait time and keeps saturating performance counters.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/src_reg_decode.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV64 base opcodes used by the decoders and the hazard FSM states.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_e;

endpackage

// File: rtl/src_reg_decode.sv
// Source-register extraction: register fields plus which of them the opcode actually reads.
module src_reg_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (instr[6:0])
      OP_LOAD, OP_ITYPE: begin
        uses_rs1 = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_RTYPE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler: load-use stalls, taken-branch flushes, data-memory freeze with timeout,
// and saturating event counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WaitLast = WW'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [WW-1:0]    wait_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2;
  logic       load_use, freeze;
  logic       sel_stall, sel_flush, sel_freeze;

  src_reg_decode u_src_reg_decode (
    .instr    (id_instr),
    .rs1      (rs1),
    .rs2      (rs2),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign load_use = ex_valid & ex_memread & id_valid & (ex_rd != 5'd0) &
                    ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
  assign freeze   = mem_req & ~mem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    sel_stall   = 1'b0;
    sel_flush   = 1'b0;
    sel_freeze  = 1'b0;
    if (state_q == ERROR || freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      sel_freeze  = (state_q != ERROR);
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use hazard on it is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      sel_flush   = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      sel_stall   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (freeze) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitLast) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        ERROR: ;
        default: state_q <= ERROR;
      endcase
      if (sel_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (sel_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (sel_freeze && freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign err        = err_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 2-bit counters covers saturation.
module tb_pipeline_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned CW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid, ex_valid, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic [4:0]  ex_rd;

  logic          pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, err;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic          s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_idex_bubble;
  logic          s_ifid_flush, s_err;
  logic [1:0]    s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush}
  wire [5:0] ctl = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush};
  localparam logic [5:0] CtlNormal = 6'b111100;
  localparam logic [5:0] CtlStall  = 6'b001110;
  localparam logic [5:0] CtlFlush  = 6'b111111;
  localparam logic [5:0] CtlFrozen = 6'b000000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .ex_valid(ex_valid),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .freeze_cnt(freeze_cnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .ex_valid(ex_valid),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_write(s_idex_write), .exmem_write(s_exmem_write), .idex_bubble(s_idex_bubble),
    .ifid_flush(s_ifid_flush), .err(s_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .freeze_cnt(s_freeze_cnt)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] ld_type(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_instr        = 32'h0000_0013;
    id_valid        = 1'b0;
    ex_valid        = 1'b0;
    ex_memread      = 1'b0;
    ex_rd           = 5'd0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_instr   = r_type(5'd7, 5'd5, 5'd6);
    id_valid   = 1'b1;
    ex_valid   = 1'b1;
    ex_memread = 1'b1;
    ex_rd      = rd;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CtlNormal);
    end
    checks++;
    if ({err, stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: err=%b stall=%0d flush=%0d freeze=%0d want all 0",
               err, stall_cnt, flush_cnt, freeze_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL load_use_ctl: got %b want %b", ctl, CtlStall);
    end
    step();
    checks++;
    if (stall_cnt !== CW'(1)) begin
      errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    ex_memread = 1'b0;
    #1;
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL load_use_release: got %b want %b", ctl, CtlNormal);
    end
    // rs2 match also stalls
    set_load_use(5'd6);
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL load_use_rs2: got %b want %b", ctl, CtlStall);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_load_use(5'd0);
    id_instr = r_type(5'd7, 5'd0, 5'd6);
    #1;
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL x0_no_stall: got %b want %b", ctl, CtlNormal);
    end
    set_load_use(5'd6);
    id_instr = ld_type(5'd8, 5'd5, 12'd6);
    #1;
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL ld_rs2_ignored: got %b want %b", ctl, CtlNormal);
    end
    set_load_use(5'd5);
    id_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL id_invalid: got %b want %b", ctl, CtlNormal);
    end
    step();
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL no_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_branch_collision();
    do_reset();
    set_load_use(5'd5);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL branch_ctl: got %b want %b", ctl, CtlFlush);
    end
    step();
    checks++;
    if (flush_cnt !== CW'(1) || stall_cnt !== '0) begin
      errors++; $display("FAIL branch_cnt: flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CtlFrozen) begin
        errors++; $display("FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, CtlFrozen);
      end
      step();
      checks++;
      if (dut.state_q !== MEM_WAIT) begin
        errors++; $display("FAIL mem_wait_state[%0d]: got %0d want %0d", i, dut.state_q, MEM_WAIT);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlNormal) begin
      errors++; $display("FAIL mem_release_ctl: got %b want %b", ctl, CtlNormal);
    end
    step();
    checks++;
    if (freeze_cnt !== CW'(3) || dut.state_q !== RUN || err !== 1'b0) begin
      errors++;
      $display("FAIL mem_release_state: freeze=%0d state=%0d err=%b want 3 %0d 0",
               freeze_cnt, dut.state_q, err, RUN);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got err=%b want 0", err);
    end
    step();
    checks++;
    if (err !== 1'b1 || dut.state_q !== ERROR) begin
      errors++; $display("FAIL timeout_err: err=%b state=%0d want 1 %0d", err, dut.state_q, ERROR);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlFrozen) begin
      errors++; $display("FAIL error_ctl: got %b want %b", ctl, CtlFrozen);
    end
    mem_req = 1'b0;
    step();
    checks++;
    if (ctl !== CtlFrozen || err !== 1'b1 || freeze_cnt !== CW'(4)) begin
      errors++;
      $display("FAIL error_sticky: ctl=%b err=%b freeze=%0d want %b 1 4",
               ctl, err, freeze_cnt, CtlFrozen);
    end
    mem_req = 1'b1;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_req = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || ctl !== CtlNormal || {stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      errors++;
      $display("FAIL error_reset: err=%b ctl=%b cnts=%0d/%0d/%0d want 0 %b 0/0/0",
               err, ctl, stall_cnt, flush_cnt, freeze_cnt, CtlNormal);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(5'd5);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (s_stall_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_stall: got %0d want 3", s_stall_cnt);
    end
    checks++;
    if (stall_cnt !== CW'(5)) begin
      errors++; $display("FAIL wide_stall: got %0d want 5", stall_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_collision();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
